one_wire_serializer: RTL

Parametrised successor to the 1-Wire UID shifter. It accepts a parallel word through a valid/ready handshake and serialises a per-frame number of bits, LSB- or MSB-first, with a programmable bit period. It drives the serial bit, a per-bit strobe and a frame-active flag to the downstream CRC/line driver, and reports frame completion. It sits between the data-control block and the 1-Wire CRC and line-timing logic.

---
 rtl/one_wire_serializer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/one_wire_serializer.sv
// Parallel-to-serial shifter for the 1-Wire path: LSB/MSB-first, per-frame length, BIT_DIV clocks/bit.
// Define ONE_WIRE_SER_CRC8_EN to append a Dallas/Maxim CRC-8 after the data bits.
module one_wire_serializer #(
    parameter int unsigned DATA_WIDTH = 56,
    parameter int unsigned BIT_DIV    = 1,
    localparam int unsigned LEN_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic [LEN_W-1:0]      i_in_len,
    input  logic                  i_in_msb_first,
    input  logic                  i_abort,
    output logic                  o_data_stream,
    output logic                  o_bit_valid,
    output logic                  o_start_crc,
    output logic                  o_busy,
    output logic                  o_frame_done
`ifdef ONE_WIRE_SER_CRC8_EN
    ,
    output logic [7:0]            o_crc_value
`endif
);

    localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_WIDTH);

`ifdef ONE_WIRE_SER_CRC8_EN
    typedef enum logic [1:0] {StIdle, StShift, StCrc, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_word, w_word_nxt;
    logic [LEN_W-1:0]      r_last, w_last_nxt;
    logic [LEN_W-1:0]      r_bit_idx, w_bit_idx_nxt;
    logic                  r_msb, w_msb_nxt;
    logic [DIV_W-1:0]      r_div, w_div_nxt;

    logic [LEN_W-1:0]      w_eff_len;
    logic [LEN_W-1:0]      w_sel_idx;
    logic                  w_data_bit;

`ifdef ONE_WIRE_SER_CRC8_EN
    logic [7:0] r_crc, w_crc_nxt;
    logic [2:0] r_crc_idx, w_crc_idx_nxt;

    // Reflected form of x^8+x^5+x^4+1: the polynomial bits reversed give 0x8C.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? 8'h8C : 8'h00);
    endfunction

    assign o_crc_value = r_crc;
`endif

    // Lengths of 0 or beyond the word width mean a full word.
    assign w_eff_len = ((i_in_len == '0) || (i_in_len > FULL_LEN)) ? FULL_LEN : i_in_len;

    assign w_sel_idx  = r_msb ? (r_last - r_bit_idx) : r_bit_idx;
    assign w_data_bit = |(r_word & (DATA_WIDTH'(1) << w_sel_idx));

    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_last_nxt    = r_last;
        w_bit_idx_nxt = r_bit_idx;
        w_msb_nxt     = r_msb;
        w_div_nxt     = r_div;
`ifdef ONE_WIRE_SER_CRC8_EN
        w_crc_nxt     = r_crc;
        w_crc_idx_nxt = r_crc_idx;
`endif
        if ((r_state != StIdle) && i_abort) begin
            w_state_nxt   = StIdle;
            w_bit_idx_nxt = '0;
            w_div_nxt     = '0;
`ifdef ONE_WIRE_SER_CRC8_EN
            w_crc_nxt     = 8'h00;
            w_crc_idx_nxt = 3'd0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        w_word_nxt    = i_in_data;
                        w_last_nxt    = w_eff_len - LEN_W'(1);
                        w_msb_nxt     = i_in_msb_first;
                        w_bit_idx_nxt = '0;
                        w_div_nxt     = '0;
`ifdef ONE_WIRE_SER_CRC8_EN
                        w_crc_nxt     = 8'h00;
                        w_crc_idx_nxt = 3'd0;
`endif
                        w_state_nxt   = StShift;
                    end
                end
                StShift: begin
`ifdef ONE_WIRE_SER_CRC8_EN
                    if (r_div == '0) begin
                        w_crc_nxt = crc8_step(r_crc, w_data_bit);
                    end
`endif
                    if (r_div == DIV_LAST) begin
                        w_div_nxt = '0;
                        if (r_bit_idx == r_last) begin
                            w_bit_idx_nxt = '0;
`ifdef ONE_WIRE_SER_CRC8_EN
                            w_state_nxt   = StCrc;
`else
                            w_state_nxt   = StDone;
`endif
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + LEN_W'(1);
                        end
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
`ifdef ONE_WIRE_SER_CRC8_EN
                StCrc: begin
                    if (r_div == DIV_LAST) begin
                        w_div_nxt = '0;
                        if (r_crc_idx == 3'd7) begin
                            w_crc_idx_nxt = 3'd0;
                            w_state_nxt   = StDone;
                        end else begin
                            w_crc_idx_nxt = r_crc_idx + 3'd1;
                        end
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
`endif
                StDone:  w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_word    <= '0;
            r_last    <= '0;
            r_bit_idx <= '0;
            r_msb     <= 1'b0;
            r_div     <= '0;
`ifdef ONE_WIRE_SER_CRC8_EN
            r_crc     <= 8'h00;
            r_crc_idx <= 3'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_last    <= w_last_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_msb     <= w_msb_nxt;
            r_div     <= w_div_nxt;
`ifdef ONE_WIRE_SER_CRC8_EN
            r_crc     <= w_crc_nxt;
            r_crc_idx <= w_crc_idx_nxt;
`endif
        end
    end

    always_comb begin
        o_in_ready    = 1'b0;
        o_busy        = 1'b1;
        o_frame_done  = 1'b0;
        o_start_crc   = 1'b0;
        o_bit_valid   = 1'b0;
        o_data_stream = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
            end
            StShift: begin
                o_start_crc   = 1'b1;
                o_bit_valid   = (r_div == '0);
                o_data_stream = w_data_bit;
            end
`ifdef ONE_WIRE_SER_CRC8_EN
            StCrc: begin
                o_start_crc   = 1'b1;
                o_bit_valid   = (r_div == '0);
                o_data_stream = r_crc[r_crc_idx];
            end
`endif
            StDone:  o_frame_done = 1'b1;
            default: o_busy = 1'b1;
        endcase
    end

endmodule
